// File: rtl/hamm_rx_deser.sv
// hamm_rx_deser: serial-to-parallel receiver for one W-bit codeword with valid/ready output; HAMM_RX_PARITY_CHK_EN adds an even-parity bit check.
module hamm_rx_deser #(
  parameter int W  = 6,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         sin_en,
  output logic [W-1:0] r_out,
  output logic         r_valid,
  input  logic         r_ready,
  output logic         busy,
  output logic         overrun,
  output logic         frame_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef HAMM_RX_PARITY_CHK_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d, r_out_q, r_out_d, shifted, word;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          r_valid_q, r_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic          last, complete, accept;
  always_comb begin
    shifted     = W'({sreg_q, sin});
    last        = state_q == SHIFT && sin_en && cnt_q == CW'(W - 1);
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    if (sin_en && state_q == IDLE && sin) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else if (sin_en && state_q == SHIFT) begin
      sreg_d = shifted;
      cnt_d  = cnt_q + 1'b1;
    end
`ifdef HAMM_RX_PARITY_CHK_EN
    word        = sreg_q;
    complete    = state_q == PAR && sin_en && !(^{sreg_q, sin});
    frame_err_d = state_q == PAR && sin_en && (^{sreg_q, sin});
    if (last) state_d = PAR;
    if (state_q == PAR && sin_en) state_d = IDLE;
`else
    word     = shifted;
    complete = last;
    if (last) state_d = IDLE;
`endif
    // a consume in the same cycle frees the slot for the completing word
    accept    = complete && (!r_valid_q || r_ready);
    r_valid_d = accept || (r_valid_q && !r_ready);
    r_out_d   = accept ? word : r_out_q;
    overrun_d = complete && !accept;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      r_out_q     <= '0;
      r_valid_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      r_out_q     <= r_out_d;
      r_valid_q   <= r_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign r_out     = r_out_q;
  assign r_valid   = r_valid_q;
  assign busy      = state_q != IDLE;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
endmodule

// File: doc/hamm_rx_deser.md
Name: hamm_rx_deser

Overview:
- Serial-to-parallel receive stage placed directly upstream of the Hamming (6,3) decoder.
- Detects a start bit on a strobed serial line, shifts in one W-bit received codeword MSB-first, and holds it in a single-entry output register.
- Presents the word to the decoder through a valid/ready handshake and flags any word lost to backpressure.

Parameters:
- W, 6, codeword width in bits; must be ≥2. Matches the decoder's r input width.
- CW, $clog2(W), bit-counter width.

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data line; sampled only when sin_en=1.
- sin_en  input  1  bit strobe; one serial bit per cycle with sin_en=1.
- r_out  output  W  received codeword, MSB = first data bit received.
- r_valid  output  1  r_out holds an unconsumed word.
- r_ready  input  1  downstream accepts r_out this cycle when r_valid=1.
- busy  output  1  frame in progress (state ≠ IDLE).
- overrun  output  1  one-cycle pulse: completed word dropped because the output register was full.
- frame_err  output  1  one-cycle pulse: parity failure (only with PARITY_CHK_EN; otherwise tied 0).

Behaviour:
- Reset (rst=1 at posedge) overrides everything. Values after reset:
  - state=IDLE; shift register=0; bit counter=0.
  - r_out=0, r_valid=0, busy=0, overrun=0, frame_err=0.
  - A partial frame is discarded. A held word is discarded.
- FSM states: IDLE, SHIFT, PAR (PAR exists only with PARITY_CHK_EN).
- IDLE:
  - sin_en=1 and sin=1 (start bit) → SHIFT, counter=0.
  - sin_en=1 and sin=0 is ignored.
- SHIFT:
  - Each sin_en=1 cycle: sreg ← {sreg[W-2:0], sin}; counter++.
  - sin_en=0: hold all state. Gaps of any length are legal.
  - On the strobe that delivers bit W-1 (counter == W-1):
    - without the macro → "complete" the word, then go to IDLE;
    - with the macro → go to PAR.
- Complete (registered; takes effect on the same posedge as the last data bit):
  - If r_valid=0, or r_valid=1 and r_ready=1 in that cycle: r_out ← {sreg[W-2:0], sin} and r_valid ← 1.
  - Otherwise: r_out and r_valid are unchanged, the word is dropped, and overrun pulses high for exactly 1 cycle.
- Latency: r_valid is visible in the cycle after the final data-bit strobe (1 clk).
- Handshake:
  - r_valid=1 and r_ready=1 and no complete this cycle → r_valid ← 0; r_out retains its last value.
  - Consume and complete in the same cycle → the new word is loaded and r_valid stays 1 (no bubble, no overrun).
  - r_ready while r_valid=0 has no effect.
  - r_out is stable while r_valid=1 and not consumed.
- busy = (state ≠ IDLE).
- A start bit that arrives while r_valid=1 is still accepted; a full output register does not block reception.
- Back-to-back frames are allowed: the start bit of the next frame may arrive on the strobe right after the last bit of the previous frame.

Optional Feature:
- Macro: HAMM_RX_PARITY_CHK_EN.
- Defined:
  - After the W data bits, one extra even-parity bit is received in state PAR (next sin_en=1 cycle).
  - If ^{word, parity bit} == 0: perform complete with the word, then go to IDLE.
  - Otherwise: discard the word, frame_err pulses for 1 cycle, r_valid/r_out are unchanged, overrun stays 0, go to IDLE.
  - Latency becomes 1 clk after the parity strobe.
- Undefined: no PAR state, no parity bit on the line, frame_err constantly 0.

Test Plan:
- Reset, r_ready=0; strobe sin = 1, 1,0,1,0,1,1 on consecutive cycles → r_out=6'b101011, r_valid=1 one cycle after the last strobe; busy=1 for the 6 data-bit cycles.
- With word 6'b101011 held (r_ready=0), send frame 0,1,1,1,0,0 → overrun pulses 1 cycle; r_out stays 6'b101011; r_valid=1. Then r_ready=1 for 1 cycle → r_valid=0.
- r_valid=1 holding 6'b000111; assert r_ready exactly on the last strobe of frame 6'b110000 → next cycle r_out=6'b110000, r_valid=1, overrun=0.
- Frame 6'b010101 with 2-cycle sin_en=0 gaps between bits, plus sin=0 idle strobes beforehand → r_out=6'b010101; the idle zeros are ignored.
- Start bit + 3 data bits, then rst=1 for 1 cycle → state IDLE, r_valid=0, busy=0. A fresh frame 6'b111000 then decodes correctly.
- With HAMM_RX_PARITY_CHK_EN:
  - Frame 6'b101011 + parity 0 → r_out=6'b101011, r_valid=1.
  - Same word + parity 1 → frame_err 1-cycle pulse, r_valid unchanged.
